// File: rtl/fifo_frame_pkg.sv
// Shared types and helpers for the FIFO write-side framer.
// Trailer arithmetic lives here so model and RTL agree on it.
package fifo_frame_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_MAX_LEN    = 64;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int FT_W           = 64;

  typedef enum logic {
    ST_PASS    = 1'b0,
    ST_TRAILER = 1'b1
  } wr_state_e;

  function automatic logic [FT_W-1:0] frame_trailer(
    input logic [FT_W-1:0] sum,
    input logic [FT_W-1:0] data
  );
    return -(sum + data);
  endfunction

endpackage

// File: rtl/fifo_frame_writer_if.sv
// Upstream byte-stream handshake for the FIFO framer.
// Beat is taken when s_valid and s_ready are both high.
interface fifo_frame_writer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_last;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/frame_skid_buf.sv
// Two-entry in-order buffer between framer and FIFO write port.
// Entry 0 is always the head; entry 1 only valid when count is 2.
module frame_skid_buf #(
  parameter int W = 9
) (
  input  logic         write_clk,
  input  logic         write_rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] ent0_q, ent0_d;
  logic [W-1:0] ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d;

  // shift/fill the entries so order is kept on push+pop
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    unique case (1'b1)
      push_i && !pop_i: begin
        if (cnt_q == 2'd0) ent0_d = push_data_i;
        else               ent1_d = push_data_i;
        cnt_d = cnt_q + 2'd1;
      end
      !push_i && pop_i: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      push_i && pop_i: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_data_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  // entry and count registers, cleared on reset
  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = ent0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/fifo_frame_writer.sv
// Frames an upstream byte stream into the async FIFO write port,
// appending a checksum trailer that zeroes the frame sum.
module fifo_frame_writer
  import fifo_frame_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_LEN    = DEF_MAX_LEN,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  write_clk,
  input  logic                  write_rst,
  fifo_frame_writer_if.slave    s,
  input  logic                  fifo_full,
  output logic                  write_enable,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic [CNT_WIDTH-1:0]  frames_written,
  output logic                  err_truncated
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int BW = DATA_WIDTH + 1;

  wr_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [DATA_WIDTH-1:0] trl_q, trl_d;
  logic [LW-1:0]         len_q, len_d;
  logic [CNT_WIDTH-1:0]  fw_q, fw_d;
  logic                  err_q, err_d;

  logic                  push;
  logic [BW-1:0]         push_data;
  logic                  pop;
  logic [BW-1:0]         head;
  logic [1:0]            count;
  logic                  accept;
  logic [LW-1:0]         len_inc;
  logic                  at_max;

  frame_skid_buf #(
    .W (BW)
  ) u_buf (
    .write_clk   (write_clk),
    .write_rst   (write_rst),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  // ready depends only on registered state, never on fifo_full
  assign s.s_ready    = write_rst && (state_q == ST_PASS)
                     && (count < 2'd2);
  assign accept       = s.s_valid && s.s_ready;
  assign write_enable = (count != 2'd0);
  assign write_data   = head[DATA_WIDTH-1:0];
  assign pop          = write_enable && !fifo_full;
  assign len_inc      = len_q + LW'(1);
  assign at_max       = (len_inc == LW'(MAX_LEN));

  // framing FSM: pass data beats, then insert one trailer
  always_comb begin
    state_d   = state_q;
    sum_d     = sum_q;
    trl_d     = trl_q;
    len_d     = len_q;
    err_d     = err_q;
    fw_d      = fw_q;
    push      = 1'b0;
    push_data = '0;
    unique case (1'b1)
      state_q == ST_PASS: begin
        if (accept) begin
          push      = 1'b1;
          push_data = {1'b0, s.s_data};
          sum_d     = sum_q + s.s_data;
          len_d     = len_inc;
          if (s.s_last || at_max) begin
            state_d = ST_TRAILER;
            trl_d   = DATA_WIDTH'(frame_trailer(
                        FT_W'(sum_q), FT_W'(s.s_data)));
          end
          if (at_max && !s.s_last) err_d = 1'b1;
        end
      end
      state_q == ST_TRAILER: begin
        if (count < 2'd2) begin
          push      = 1'b1;
          push_data = {1'b1, trl_q};
          sum_d     = '0;
          len_d     = '0;
          state_d   = ST_PASS;
        end
      end
      default: ;
    endcase
    if (pop && head[DATA_WIDTH]) fw_d = fw_q + CNT_WIDTH'(1);
  end

  // framing state, running sum and status counters
  always_ff @(posedge write_clk or negedge write_rst) begin
    if (!write_rst) begin
      state_q <= ST_PASS;
      sum_q   <= '0;
      trl_q   <= '0;
      len_q   <= '0;
      fw_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      trl_q   <= trl_d;
      len_q   <= len_d;
      fw_q    <= fw_d;
      err_q   <= err_d;
    end
  end

  assign frames_written = fw_q;
  assign err_truncated  = err_q;

endmodule
